// File: rtl/wash_timer_arbiter.sv
// ============================================================================
//  Module   : wash_timer_arbiter
//  Brief    : Shared round-robin arbitrated down-counter timer for washer steps.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module wash_timer_arbiter #(
   parameter int NREQ = 4,
   parameter int DW   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req_i,
   input  logic [NREQ*DW-1:0] dur_i,
   input  logic               pause_i,
   output logic [NREQ-1:0]    grant_o,
   output logic [NREQ-1:0]    done_o,
   output logic               busy_o,
   output logic [DW-1:0]      remaining_o
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [PW:0]   C_NREQ = (PW+1)'(NREQ);
   localparam logic [PW-1:0] C_LAST = PW'(NREQ - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_COUNT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t            state_q;
   logic [PW-1:0]     ptr_q;
   logic [NREQ-1:0]   grant_q;
   logic [NREQ-1:0]   done_q;
   logic              busy_q;
   logic [DW-1:0]     remaining_q;

   logic [2*NREQ-1:0] req_dbl_d;
   logic [NREQ-1:0]   req_rot_d;
   logic              win_vld_d;
   logic [PW-1:0]     win_off_d;
   logic [PW:0]       win_sum_d;
   logic [PW-1:0]     win_idx_d;
   logic [PW-1:0]     ptr_d;
   logic [DW-1:0]     win_dur_d;

   // Rotate requests so the pointer position lands at bit 0; the lowest set
   // bit of the rotated vector is the round-robin winner's offset.
   always_comb begin
      req_dbl_d = {req_i, req_i};
      req_rot_d = req_dbl_d[ptr_q +: NREQ];
      win_vld_d = 1'b0;
      win_off_d = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req_rot_d[k]) begin
            win_vld_d = 1'b1;
            win_off_d = PW'(k);
         end
      end
      win_sum_d = {1'b0, ptr_q} + {1'b0, win_off_d};
      win_idx_d = (win_sum_d >= C_NREQ) ? PW'(win_sum_d - C_NREQ) : PW'(win_sum_d);
      ptr_d     = (win_idx_d == C_LAST) ? '0 : win_idx_d + PW'(1);
      win_dur_d = dur_i[win_idx_d*DW +: DW];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         grant_q     <= '0;
         done_q      <= '0;
         busy_q      <= 1'b0;
         remaining_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (!pause_i && win_vld_d) begin
                  state_q     <= S_COUNT;
                  grant_q     <= NREQ'(1) << win_idx_d;
                  remaining_q <= win_dur_d;
                  ptr_q       <= ptr_d;
                  busy_q      <= 1'b1;
               end
            end
            S_COUNT: begin
               // Cancel outranks pause and expiry.
               if ((grant_q & req_i) == '0) begin
                  state_q     <= S_IDLE;
                  grant_q     <= '0;
                  remaining_q <= '0;
                  busy_q      <= 1'b0;
               end else if (pause_i) begin
                  state_q     <= S_COUNT;
               end else if (remaining_q < DW'(2)) begin
                  state_q     <= S_DONE;
                  remaining_q <= '0;
                  done_q      <= grant_q;
               end else begin
                  remaining_q <= remaining_q - DW'(1);
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               grant_q <= '0;
               done_q  <= '0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q     <= S_IDLE;
               grant_q     <= '0;
               done_q      <= '0;
               busy_q      <= 1'b0;
               remaining_q <= '0;
            end
         endcase
      end
   end

   assign grant_o     = grant_q;
   assign done_o      = done_q;
   assign busy_o      = busy_q;
   assign remaining_o = remaining_q;

endmodule

`default_nettype wire

// File: tb/tb_wash_timer_arbiter.sv
// ============================================================================
//  Module   : tb_wash_timer_arbiter
//  Brief    : Directed self-checking bench for wash_timer_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wash_timer_arbiter;

   localparam int NREQ = 4;
   localparam int DW   = 8;

   logic               clk;
   logic               rst;
   logic [NREQ-1:0]    req;
   logic [NREQ*DW-1:0] dur;
   logic               pause;
   logic [NREQ-1:0]    grant;
   logic [NREQ-1:0]    done;
   logic               busy;
   logic [DW-1:0]      remaining;

   int passed;
   int total;

   wash_timer_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_i       (req),
      .dur_i       (dur),
      .pause_i     (pause),
      .grant_o     (grant),
      .done_o      (done),
      .busy_o      (busy),
      .remaining_o (remaining)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic chk_all(input string tag, input logic [3:0] g, input logic [3:0] d,
                          input logic b, input logic [7:0] r);
      chk({tag, ".grant"}, 32'(grant), 32'(g));
      chk({tag, ".done"},  32'(done),  32'(d));
      chk({tag, ".busy"},  32'(busy),  32'(b));
      chk({tag, ".rem"},   32'(remaining), 32'(r));
   endtask

   initial begin
      passed = 0;
      total  = 0;
      rst    = 1'b0;
      req    = '0;
      dur    = '0;
      pause  = 1'b0;
      tick();
      tick();
      chk_all("reset", 4'b0000, 4'b0000, 1'b0, 8'd0);
      rst = 1'b1;

      // Single request, dur=3
      dur[0*DW +: DW] = 8'd3;
      req = 4'b0001;
      tick(); chk_all("single.c1", 4'b0001, 4'b0000, 1'b1, 8'd3);
      tick(); chk_all("single.c2", 4'b0001, 4'b0000, 1'b1, 8'd2);
      tick(); chk_all("single.c3", 4'b0001, 4'b0000, 1'b1, 8'd1);
      tick(); chk_all("single.c4", 4'b0001, 4'b0001, 1'b1, 8'd0);
      req = 4'b0000;
      tick(); chk_all("single.idle", 4'b0000, 4'b0000, 1'b0, 8'd0);

      // Round-robin from a fresh pointer
      rst = 1'b0; tick(); rst = 1'b1;
      for (int i = 0; i < NREQ; i++) dur[i*DW +: DW] = 8'd2;
      req = 4'b1111;
      tick();
      for (int i = 0; i < NREQ; i++) begin
         chk_all($sformatf("rr%0d.grant", i), 4'(1 << i), 4'b0000, 1'b1, 8'd2);
         tick(); chk("rr.rem1", 32'(remaining), 32'd1);
         tick(); chk_all($sformatf("rr%0d.done", i), 4'(1 << i), 4'(1 << i), 1'b1, 8'd0);
         req[i] = 1'b0;
         tick(); chk_all($sformatf("rr%0d.gap", i), 4'b0000, 4'b0000, 1'b0, 8'd0);
         tick();
      end
      chk_all("rr.end", 4'b0000, 4'b0000, 1'b0, 8'd0);

      // Pause mid-count: requester 1, dur=4, 3 pause cycles
      dur[1*DW +: DW] = 8'd4;
      req = 4'b0010;
      tick(); chk_all("pause.g", 4'b0010, 4'b0000, 1'b1, 8'd4);
      tick(); chk("pause.r3", 32'(remaining), 32'd3);
      pause = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(); chk_all("pause.hold", 4'b0010, 4'b0000, 1'b1, 8'd3);
      end
      pause = 1'b0;
      tick(); chk("pause.r2", 32'(remaining), 32'd2);
      tick(); chk_all("pause.r1", 4'b0010, 4'b0000, 1'b1, 8'd1);
      tick(); chk_all("pause.done", 4'b0010, 4'b0010, 1'b1, 8'd0);
      req = 4'b0000;
      tick();

      // Pause in IDLE blocks grants
      pause = 1'b1;
      req   = 4'b0001;
      tick(); chk_all("idlepause.1", 4'b0000, 4'b0000, 1'b0, 8'd0);
      tick(); chk_all("idlepause.2", 4'b0000, 4'b0000, 1'b0, 8'd0);
      pause = 1'b0;

      // Cancel beats pause and expiry (pointer at 2, wraps to requester 0)
      dur[0*DW +: DW] = 8'd2;
      tick(); chk_all("cancel.g", 4'b0001, 4'b0000, 1'b1, 8'd2);
      tick(); chk("cancel.r1", 32'(remaining), 32'd1);
      req   = 4'b0000;
      pause = 1'b1;
      tick(); chk_all("cancel.idle", 4'b0000, 4'b0000, 1'b0, 8'd0);
      pause = 1'b0;
      tick(); chk("cancel.nodone", 32'(done), 32'd0);

      // dur=0 on requester 0 (pointer at 1, wraps)
      dur[0*DW +: DW] = 8'd0;
      req = 4'b0001;
      tick(); chk_all("dur0.g", 4'b0001, 4'b0000, 1'b1, 8'd0);
      tick(); chk_all("dur0.done", 4'b0001, 4'b0001, 1'b1, 8'd0);
      req = 4'b0000;
      tick();

      // dur=1 on requester 2
      dur[2*DW +: DW] = 8'd1;
      req = 4'b0100;
      tick(); chk_all("dur1.g", 4'b0100, 4'b0000, 1'b1, 8'd1);
      tick(); chk_all("dur1.done", 4'b0100, 4'b0100, 1'b1, 8'd0);
      req = 4'b0000;
      tick();

      // dur=255 on requester 3
      dur[3*DW +: DW] = 8'd255;
      req = 4'b1000;
      tick(); chk_all("dur255.g", 4'b1000, 4'b0000, 1'b1, 8'd255);
      for (int i = 0; i < 254; i++) tick();
      chk_all("dur255.r1", 4'b1000, 4'b0000, 1'b1, 8'd1);
      tick(); chk_all("dur255.done", 4'b1000, 4'b1000, 1'b1, 8'd0);
      req = 4'b0000;
      tick();

      // Reset mid-count, then requester 0 must win over 3
      dur[2*DW +: DW] = 8'd8;
      req = 4'b0100;
      tick(); chk("rstmid.r8", 32'(remaining), 32'd8);
      tick(); tick(); tick();
      chk("rstmid.r5", 32'(remaining), 32'd5);
      rst = 1'b0;
      tick(); chk_all("rstmid.reset", 4'b0000, 4'b0000, 1'b0, 8'd0);
      rst = 1'b1;
      req = 4'b1001;
      tick(); chk("rstmid.ptr0", 32'(grant), 32'b0001);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/wash_timer_arbiter.md
# wash_timer_arbiter

Shared down-counter timer with round-robin arbitration for the washer controller. Up to NREQ step sequencers (fill, wash, drain, rinse, dry) request a timed interval with a per-request duration. The block grants one requester at a time, counts the duration, freezes while paused (door open, soap wait), and returns a one-cycle done pulse to the owner. It replaces per-step timer instances with one arbitrated counter that also drives the panel's remaining-time display.

## Interface
- NREQ, 4, number of requesters (2..8)
- DW, 8, duration/counter width in cycles
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- req  in  NREQ  level request, one bit per requester; held until done or intentionally dropped
- dur  in  NREQ*DW  duration for requester i in dur[i*DW +: DW]; sampled only at grant
- pause  in  1  freezes counting and blocks new grants
- grant  out  NREQ  one-hot owner, zero when idle
- done  out  NREQ  one-cycle pulse to the owner at interval end
- busy  out  1  high in COUNT and DONE
- remaining  out  DW  current count, 0 when idle

## Operation
- States: IDLE, COUNT, DONE.
- Reset (rst=0 at edge): state IDLE, grant=0, done=0, busy=0, remaining=0, round-robin pointer=0, so requester 0 has highest priority.
- IDLE: if pause=0 and any req bit is set, the winner is the first set bit at or after the pointer, wrapping modulo NREQ. At the edge: grant=onehot(winner), remaining=dur[winner], pointer=(winner+1) mod NREQ, state→COUNT. If pause=1, stay in IDLE and grant nothing.
- COUNT, priority order:
  - req[owner]=0: cancel. Next edge goes to IDLE with grant=0 and remaining=0. No done pulse. Pointer is not restored.
  - pause=1: hold the count and state. Grant stays asserted.
  - remaining≤1: next edge goes to DONE with remaining=0.
  - Otherwise: remaining decrements by 1.
- DONE: done[owner]=1 and grant held for exactly one cycle. Next edge goes to IDLE with grant=0 and done=0. Pause and req are ignored in DONE, so done always issues once reached.
- The owner must drop req in the cycle after done. A req still high in IDLE counts as a new request, but other pending requesters win first because the pointer has advanced.
- dur=0 behaves as dur=1.
- Requests other than the owner's are ignored while busy. No queueing; they are re-evaluated in IDLE.
- Arithmetic: remaining is unsigned DW bits and never underflows. The decrement is gated by remaining>1.
- Simultaneous events: in COUNT, a cancel overrides pause and expiry. In IDLE, pause overrides all requests.

## Timing
- Grant latency: req high in IDLE at edge E gives grant from E+1. Idle to grant is one cycle.
- With no pause, done asserts at edge E+max(dur,1)+1, i.e. max(dur,1) cycles after grant first appears.
- Each cycle with pause=1 in COUNT adds exactly one cycle to that latency.
- Back-to-back turnaround: DONE→IDLE→next grant, so there is a minimum 2-cycle gap between one owner's done and the next grant.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset mid-operation (any state): next edge returns to reset values. No done pulse is emitted for the interrupted interval.

## Test plan
- Single request: req=0001, dur0=3, no pause. Expected:
  - grant=0001 for 4 cycles;
  - remaining reads 3,2,1,0;
  - done=0001 for one cycle, in the 4th grant cycle;
  - then idle, with remaining=0 and busy=0.
- Round-robin: req=1111 held, all dur=2, each owner drops req after its done. Expected grant order 0,1,2,3, with a 2-cycle gap between each done and the next grant.
- Pause: req=0010, dur1=4, pause high for 3 cycles mid-count. Expected: remaining holds its value during the pause, and done arrives 3 cycles later than in the unpaused case. Separately, with pause=1 in IDLE and req pending, grant stays 0.
- Cancel versus expiry: owner drops req in the same cycle remaining=1 while pause=1. Expected: IDLE next cycle, no done pulse, remaining=0.
- Boundary durations:
  - dur=0 and dur=1 each give done exactly 1 cycle after grant;
  - dur=255 gives done 255 cycles after grant, with no wrap of remaining.
- Reset mid-count: rst=0 for one cycle while remaining=5. Expected on the next edge: grant=0, done=0, busy=0, remaining=0, and requester 0 wins the next arbitration.
